// File: rtl/spike_scheduler_mp_pkg.sv
// Shared definitions for the multi-port spike scheduler.
//   - calc_aw / calc_tw : axon-index and slot-index widths from the core sizes
//   - pkt_axon / pkt_delay : field extraction from a packet {axon, delay}
//   - ERR_DROP / ERR_TICK : bit positions inside err_sticky
//   - sched_state_t : init / run state of the scheduler
package spike_sched_pkg;

  localparam int ERR_DROP = 0;
  localparam int ERR_TICK = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  function automatic int calc_aw(input int num_axons);
    return (num_axons > 1) ? $clog2(num_axons) : 1;
  endfunction

  function automatic int calc_tw(input int num_ticks);
    return $clog2(num_ticks);
  endfunction

  // Packets are at most 32 bits wide; callers truncate to the field width.
  function automatic logic [31:0] pkt_delay(input logic [31:0] pkt, input int tw);
    return pkt & ((32'd1 << tw) - 32'd1);
  endfunction

  function automatic logic [31:0] pkt_axon(input logic [31:0] pkt, input int tw);
    return pkt >> tw;
  endfunction

endpackage

// File: rtl/spike_scheduler_mp_if.sv
// Handshake / status bundle between the packet router, the neuron pipeline
// and the spike scheduler.
//   master : drives tick, pkt_valid, pkt_data; observes everything else
//   slave  : the scheduler itself
interface spike_scheduler_mp_if
  import spike_sched_pkg::*;
#(
  parameter int NUM_AXONS  = 256,
  parameter int NUM_TICKS  = 16,
  parameter int NUM_PORTS  = 2,
  parameter int DROP_CNT_W = 16
);
  localparam int AW    = calc_aw(NUM_AXONS);
  localparam int TW    = calc_tw(NUM_TICKS);
  localparam int PKT_W = AW + TW;

  logic                         tick;
  logic [NUM_PORTS-1:0]         pkt_valid;
  logic [NUM_PORTS*PKT_W-1:0]   pkt_data;
  logic [NUM_PORTS-1:0]         pkt_ready;
  logic [NUM_AXONS-1:0]         out_axons;
  logic                         out_valid;
  logic [TW-1:0]                read_ptr;
  logic                         init_busy;
  logic [DROP_CNT_W-1:0]        drop_cnt;
  logic [1:0]                   err_sticky;

  modport master (
    output tick, pkt_valid, pkt_data,
    input  pkt_ready, out_axons, out_valid, read_ptr, init_busy, drop_cnt, err_sticky
  );

  modport slave (
    input  tick, pkt_valid, pkt_data,
    output pkt_ready, out_axons, out_valid, read_ptr, init_busy, drop_cnt, err_sticky
  );

endinterface

// File: rtl/spike_sched_port_decode.sv
// Per-port packet decoder.
//   pkt      : {axon, delay} packet from one write port
//   read_ptr : slot the next tick will consume
//   fire     : handshake completed on this port this cycle
//   slot     : target slot, read_ptr + 1 + delay (wraps)
//   mask     : one-hot axon bit, zero unless a real write happens
//   drop     : packet would land in the slot being consumed
module spike_sched_port_decode
  import spike_sched_pkg::*;
#(
  parameter int NUM_AXONS = 256,
  parameter int NUM_TICKS = 16,
  localparam int AW    = calc_aw(NUM_AXONS),
  localparam int TW    = calc_tw(NUM_TICKS),
  localparam int PKT_W = AW + TW
) (
  input  logic [PKT_W-1:0]     pkt,
  input  logic [TW-1:0]        read_ptr,
  input  logic                 fire,
  output logic [TW-1:0]        slot,
  output logic [NUM_AXONS-1:0] mask,
  output logic                 drop
);

  logic [AW-1:0] axon;
  logic [TW-1:0] delay;

  assign axon  = AW'(pkt_axon(32'(pkt), TW));
  assign delay = TW'(pkt_delay(32'(pkt), TW));

  assign slot = read_ptr + delay + TW'(1);

  // The largest delay wraps onto read_ptr itself, which is being drained.
  assign drop = fire && (delay == TW'(NUM_TICKS - 1));
  assign mask = (fire && !drop) ? (NUM_AXONS'(1) << axon) : '0;

endmodule

// File: rtl/spike_scheduler_mp.sv
// Multi-port, self-initialising spike scheduler.
//   clk, rst : clock and synchronous active-low reset
//   bus      : slave side of spike_scheduler_mp_if (tick, packet ports,
//              delivered axon vector, read pointer, init/drop/error status)
// A NUM_TICKS x NUM_AXONS register array holds future spikes. Every port can
// set one bit per cycle; all ports OR into the array simultaneously. A tick
// delivers and clears the current slot. After reset every slot is cleared
// one per cycle before packets or ticks are accepted.
module spike_scheduler_mp
  import spike_sched_pkg::*;
#(
  parameter int NUM_AXONS  = 256,
  parameter int NUM_TICKS  = 16,
  parameter int NUM_PORTS  = 2,
  parameter int DROP_CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  spike_scheduler_mp_if.slave bus
);

  localparam int AW    = calc_aw(NUM_AXONS);
  localparam int TW    = calc_tw(NUM_TICKS);
  localparam int PKT_W = AW + TW;

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                    input logic [2:0] b);
    logic [DROP_CNT_W+2:0] s;
    s = {3'b000, a} + {{DROP_CNT_W{1'b0}}, b};
    if (s[DROP_CNT_W+2:DROP_CNT_W] != 3'b000) return '1;
    return s[DROP_CNT_W-1:0];
  endfunction

  logic [NUM_AXONS-1:0]  mem [NUM_TICKS];

  sched_state_t          state_p0;
  logic [TW-1:0]         init_cnt_p0;
  logic [TW-1:0]         rd_ptr_p0;
  logic [NUM_AXONS-1:0]  out_axons_p1;
  logic                  out_valid_p1;
  logic [DROP_CNT_W-1:0] drop_cnt_p1;
  logic [1:0]            err_p1;

  logic                  init_busy;
  logic                  ready;
  logic                  tick_fire;
  logic [NUM_PORTS-1:0]  fire;
  logic [TW-1:0]         slot_p [NUM_PORTS];
  logic [NUM_AXONS-1:0]  mask_p [NUM_PORTS];
  logic [NUM_PORTS-1:0]  drop_p;
  logic [NUM_AXONS-1:0]  set_mask [NUM_TICKS];
  logic [2:0]            n_drop;

  assign init_busy = (state_p0 == ST_INIT);
  // Ready falls combinationally with tick so no write can race the drain.
  assign ready     = !init_busy && !bus.tick;
  assign tick_fire = bus.tick && !init_busy;

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      assign fire[p] = bus.pkt_valid[p] && ready;
      spike_sched_port_decode #(
        .NUM_AXONS (NUM_AXONS),
        .NUM_TICKS (NUM_TICKS)
      ) u_decode (
        .pkt      (bus.pkt_data[p*PKT_W +: PKT_W]),
        .read_ptr (rd_ptr_p0),
        .fire     (fire[p]),
        .slot     (slot_p[p]),
        .mask     (mask_p[p]),
        .drop     (drop_p[p])
      );
    end
  endgenerate

  // Stage p0: gather per-slot set masks and the number of drops this cycle.
  always_comb begin
    for (int s = 0; s < NUM_TICKS; s++) begin
      set_mask[s] = '0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (slot_p[q] == TW'(s)) set_mask[s] = set_mask[s] | mask_p[q];
      end
    end
    n_drop = 3'd0;
    for (int q = 0; q < NUM_PORTS; q++) n_drop = n_drop + 3'(drop_p[q]);
  end

  // Slot storage: cleared by the init sweep or by the tick that drains it,
  // otherwise accumulates set bits. Held untouched while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_TICKS; s++) begin
        if ((init_busy && init_cnt_p0 == TW'(s)) || (tick_fire && rd_ptr_p0 == TW'(s)))
          mem[s] <= '0;
        else
          mem[s] <= mem[s] | set_mask[s];
      end
    end
  end

  // Stage p1: control state, delivered slot and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p0     <= ST_INIT;
      init_cnt_p0  <= '0;
      rd_ptr_p0    <= '0;
      out_axons_p1 <= '0;
      out_valid_p1 <= 1'b0;
      drop_cnt_p1  <= '0;
      err_p1       <= 2'b00;
    end else begin
      out_valid_p1 <= tick_fire;
      case (state_p0)
        ST_INIT: begin
          init_cnt_p0 <= init_cnt_p0 + TW'(1);
          if (init_cnt_p0 == TW'(NUM_TICKS - 1)) state_p0 <= ST_RUN;
          if (bus.tick) err_p1[ERR_TICK] <= 1'b1;
        end
        ST_RUN: begin
          if (tick_fire) begin
            out_axons_p1 <= mem[rd_ptr_p0];
            rd_ptr_p0    <= rd_ptr_p0 + TW'(1);
          end
        end
        default: state_p0 <= ST_INIT;
      endcase
      if (n_drop != 3'd0) begin
        drop_cnt_p1      <= sat_add(drop_cnt_p1, n_drop);
        err_p1[ERR_DROP] <= 1'b1;
      end
    end
  end

  assign bus.pkt_ready  = {NUM_PORTS{ready}};
  assign bus.out_axons  = out_axons_p1;
  assign bus.out_valid  = out_valid_p1;
  assign bus.read_ptr   = rd_ptr_p0;
  assign bus.init_busy  = init_busy;
  assign bus.drop_cnt   = drop_cnt_p1;
  assign bus.err_sticky = err_p1;

endmodule

// File: tb/tb_spike_scheduler_mp.sv
// Bench for spike_scheduler_mp. dut1 uses the default sizes and is tracked
// every cycle by a spike-list model (each accepted spike carries the tick
// number on which it is due). dut2 is a tiny instance with a 2-bit drop
// counter used to reach counter saturation and multi-drop accumulation.
module tb_spike_scheduler_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spike_scheduler_mp_if #(.NUM_AXONS(256), .NUM_TICKS(16), .NUM_PORTS(2), .DROP_CNT_W(16)) bus1 ();
  spike_scheduler_mp_if #(.NUM_AXONS(8),   .NUM_TICKS(4),  .NUM_PORTS(2), .DROP_CNT_W(2))  bus2 ();

  spike_scheduler_mp #(.NUM_AXONS(256), .NUM_TICKS(16), .NUM_PORTS(2), .DROP_CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  spike_scheduler_mp #(.NUM_AXONS(8), .NUM_TICKS(4), .NUM_PORTS(2), .DROP_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut1 ----------------
  typedef struct { int axon; int due; } spk_t;
  spk_t         pend[$];
  int           nt        = 0;   // ticks delivered since init
  int           busy_left = 16;
  logic [255:0] m_out     = '0;
  bit           m_valid   = 1'b0;
  logic [15:0]  m_drop    = '0;
  logic [1:0]   m_err     = 2'b00;

  always @(posedge clk) begin
    bit busy;
    if (!rst) begin
      busy_left = 16; nt = 0; pend.delete();
      m_out = '0; m_valid = 1'b0; m_drop = '0; m_err = 2'b00;
    end else begin
      busy    = (busy_left > 0);
      m_valid = 1'b0;
      if (bus1.tick) begin
        if (busy) m_err[1] = 1'b1;
        else begin
          nt++;
          m_out = '0;
          for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].due == nt) begin
              m_out[pend[i].axon] = 1'b1;
              pend.delete(i);
            end
          m_valid = 1'b1;
        end
      end else if (!busy) begin
        for (int q = 0; q < 2; q++)
          if (bus1.pkt_valid[q]) begin
            int a, d;
            d = int'(bus1.pkt_data[q*12 +: 4]);
            a = int'(bus1.pkt_data[q*12+4 +: 8]);
            if (d == 15) begin
              if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
              m_err[0] = 1'b1;
            end else pend.push_back('{a, nt + d + 2});
          end
      end
      if (busy) busy_left--;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("read_ptr",   256'(bus1.read_ptr),   256'(nt % 16));
      chk("init_busy",  256'(bus1.init_busy),  256'(busy_left > 0));
      chk("pkt_ready",  256'(bus1.pkt_ready),  (busy_left == 0 && !bus1.tick) ? 256'd3 : 256'd0);
      chk("out_valid",  256'(bus1.out_valid),  256'(m_valid));
      chk("out_axons",  bus1.out_axons,        m_out);
      chk("drop_cnt",   256'(bus1.drop_cnt),   256'(m_drop));
      chk("err_sticky", 256'(bus1.err_sticky), 256'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus1.tick = 1'b0; bus1.pkt_valid = 2'b00;
    bus2.tick = 1'b0; bus2.pkt_valid = 2'b00;
  endtask

  task automatic put1(input int q, input int a, input int d);
    bus1.pkt_valid[q] = 1'b1;
    bus1.pkt_data[q*12 +: 12] = {8'(a), 4'(d)};
  endtask

  task automatic put2(input int q, input int a, input int d);
    bus2.pkt_valid[q] = 1'b1;
    bus2.pkt_data[q*5 +: 5] = {3'(a), 2'(d)};
  endtask

  task automatic tick1();
    bus1.tick = 1'b1; cyc(); bus1.tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] both;
    bus1.pkt_data = '0; bus2.pkt_data = '0;
    idle();
    rst = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_init_busy", 256'(bus1.init_busy), 256'd1);
    chk("rst_read_ptr",  256'(bus1.read_ptr),  256'd0);
    chk("rst_ready",     256'(bus1.pkt_ready), 256'd0);
    chk("rst_err",       256'(bus1.err_sticky), 256'd0);

    // Init: packets offered throughout must not be taken; tick on cycle 5 ignored.
    rst = 1'b1;
    put1(0, 5, 1); put1(1, 6, 2);
    repeat (4) cyc();
    tick1();
    chk("init_tick_err", 256'(bus1.err_sticky), 256'd2);
    chk("init_tick_rp",  256'(bus1.read_ptr),   256'd0);
    chk("init_ready",    256'(bus1.pkt_ready),  256'd0);
    repeat (10) cyc();
    chk("init_still_busy", 256'(bus1.init_busy), 256'd1);
    cyc();
    chk("init_done", 256'(bus1.init_busy), 256'd0);
    idle();

    // Single spike, delay 0.
    put1(0, 7, 0); cyc(); idle();
    tick1();
    chk("t1_axons", bus1.out_axons, 256'd0);
    tick1();
    chk("t2_axons", bus1.out_axons, 256'h80);
    chk("t2_rp",    256'(bus1.read_ptr), 256'd2);

    // Two ports, same target, then identical packets on both ports.
    put1(0, 3, 4); put1(1, 200, 4); cyc(); idle();
    put1(0, 9, 2); put1(1, 9, 2);   cyc(); idle();
    both = (256'd1 << 200) | 256'd8;
    for (int i = 0; i < 6; i++) begin
      tick1();
      if (i == 3) chk("same_bit9", bus1.out_axons, 256'h200);
      if (i == 5) chk("pair_3_200", bus1.out_axons, both);
    end

    // Drop: delay 15 is handshaken but never delivered.
    put1(1, 1, 15);
    #1 chk("drop_ready", 256'(bus1.pkt_ready), 256'd3);
    cyc(); idle();
    chk("drop_cnt1", 256'(bus1.drop_cnt),   256'd1);
    chk("drop_err",  256'(bus1.err_sticky), 256'd3);
    repeat (16) tick1();

    // Wrap: spike targeting slot 3 from read_ptr 8, then 20 back-to-back ticks
    // with packets held valid during ticks and real writes interleaved.
    put1(0, 100, 10); cyc(); idle();
    for (int i = 0; i < 20; i++) begin
      put1(0, 77, 15); put1(1, 78, 1);
      tick1();
      idle();
      if (i == 11) chk("wrap_bit100", 256'(bus1.out_axons[100]), 256'd1);
      if (i % 3 == 0) begin
        put1(i % 2, 20 + i, (i * 7) % 15); cyc(); idle();
      end
    end
    chk("wrap_rp", 256'(bus1.read_ptr), 256'd12);

    // Reset mid-stream with pending spikes.
    put1(0, 50, 3); put1(1, 51, 0); cyc(); idle();
    rst = 1'b0; cyc();
    chk("mid_rst_busy",  256'(bus1.init_busy),  256'd1);
    chk("mid_rst_rp",    256'(bus1.read_ptr),   256'd0);
    chk("mid_rst_axons", bus1.out_axons,        256'd0);
    chk("mid_rst_drop",  256'(bus1.drop_cnt),   256'd0);
    chk("mid_rst_err",   256'(bus1.err_sticky), 256'd0);
    rst = 1'b1;
    repeat (16) cyc();
    for (int i = 0; i < 16; i++) begin
      tick1();
      chk("reinit_zero", bus1.out_axons, 256'd0);
    end

    // Small instance: multi-drop accumulation and saturation of a 2-bit counter.
    put2(0, 1, 3); put2(1, 2, 3); cyc(); idle();
    chk("d2_cnt2", 256'(bus2.drop_cnt), 256'd2);
    chk("d2_err",  256'(bus2.err_sticky), 256'd1);
    put2(0, 1, 3); put2(1, 2, 3); cyc(); idle();
    chk("d2_sat", 256'(bus2.drop_cnt), 256'd3);
    put2(0, 4, 3); cyc(); idle();
    chk("d2_hold", 256'(bus2.drop_cnt), 256'd3);
    put2(0, 5, 0); cyc(); idle();
    bus2.tick = 1'b1; cyc(); cyc(); bus2.tick = 1'b0;
    chk("d2_deliver", 256'(bus2.out_axons), 256'h20);
    chk("d2_rp",      256'(bus2.read_ptr),  256'd2);
    cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
